// File: rtl/spi_display_receiver_pkg.sv
// ---------------------------------------------------------------------------
// spi_display_pkg
// Shared definitions for the SPI 7-segment display receiver:
//   - register address map (4-bit address field of each frame)
//   - frame length
//   - receiver state encoding
//   - Code-B font lookup (segment order: bit6 = A ... bit0 = G, DP excluded)
// ---------------------------------------------------------------------------
package spi_display_pkg;

    localparam int FRAME_BITS = 16;

    localparam logic [3:0] ADDR_NOOP      = 4'h0;
    localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
    localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
    localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
    localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
    localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
    localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
    localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
    localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
    localparam logic [3:0] ADDR_DECODE    = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY = 4'hA;
    localparam logic [3:0] ADDR_SCANLIMIT = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
    localparam logic [3:0] ADDR_TEST      = 4'hF;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } rx_state_e;

    // Code-B font: 0-9, then '-', E, H, L, P, blank.
    function automatic logic [6:0] code_b_font(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h7E;
            4'h1:    seg = 7'h30;
            4'h2:    seg = 7'h6D;
            4'h3:    seg = 7'h79;
            4'h4:    seg = 7'h33;
            4'h5:    seg = 7'h5B;
            4'h6:    seg = 7'h5F;
            4'h7:    seg = 7'h70;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h7B;
            4'hA:    seg = 7'h01;
            4'hB:    seg = 7'h4F;
            4'hC:    seg = 7'h37;
            4'hD:    seg = 7'h0E;
            4'hE:    seg = 7'h67;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/spi_display_receiver_if.sv
// ---------------------------------------------------------------------------
// spi_display_if
// SPI link to the display receiver.
//   sck  : serial clock, data sampled on rising edge
//   cs   : chip select, active low
//   mosi : serial data, MSB first
// Modports: master drives the link, slave (the receiver) observes it.
// ---------------------------------------------------------------------------
interface spi_display_if;
    logic sck;
    logic cs;
    logic mosi;

    modport master (output sck, output cs, output mosi);
    modport slave  (input  sck, input  cs, input  mosi);
endinterface

// File: rtl/spi_display_receiver_sync.sv
// ---------------------------------------------------------------------------
// spi_rx_sync
// Brings one asynchronous input into the clk domain and flags its edges.
//   clk, res : system clock, asynchronous active-low reset
//   din      : asynchronous input
//   level    : synchronized level, aligned with rise/fall
//   rise     : one-cycle pulse on a synchronized rising edge
//   fall     : one-cycle pulse on a synchronized falling edge
// Parameters: STAGES (synchronizer depth, >= 2), RESET_VAL (idle level).
// ---------------------------------------------------------------------------
module spi_rx_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic res,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_q, chain_d;
    logic              prev_q,  prev_d;
    // Tracks which pipeline slots hold real pin samples rather than reset
    // values, so that a pin already at the non-idle level when reset is
    // released does not look like an edge.
    logic [STAGES:0]   vld_q,   vld_d;
    logic              rise_q,  rise_d;
    logic              fall_q,  fall_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], din};
        prev_d  = chain_q[STAGES-1];
        vld_d   = {vld_q[STAGES-1:0], 1'b1};
        rise_d  = vld_q[STAGES] &  chain_q[STAGES-1] & ~prev_q;
        fall_d  = vld_q[STAGES] & ~chain_q[STAGES-1] &  prev_q;
    end

    // NOTE: non-blocking assignments in clocked logic so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the
    // synchronizer chain into a single stage.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            chain_q <= {STAGES{RESET_VAL}};
            prev_q  <= RESET_VAL;
            vld_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
            vld_q   <= vld_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = prev_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/spi_display_receiver.sv
// ---------------------------------------------------------------------------
// spi_display_receiver
// SPI responder modelling a 7-segment display driver. Receives 16-bit
// MSB-first {address, data} frames delimited by cs and updates the digit,
// decode-mode, intensity, scan-limit, shutdown and display-test registers.
// Oversampled in the clk domain (clk >= 4x sck).
//
// Ports:
//   clk, res     : system clock, asynchronous active-low reset
//   spi          : spi_display_if.slave (sck, cs, mosi)
//   word_valid   : one-cycle pulse when a 16-bit frame is committed
//   word_out     : last committed frame
//   frame_err    : one-cycle pulse when a frame of the wrong length ends
//   digits       : digit i at [8i+7:8i], digit 0 is address 0x1
//   decode_mode, intensity, scan_limit, shutdown, display_test : registers
//   segs         : decoded segments, only when SPI_RX_CODEB_EN is defined
//
// Optional feature macro: SPI_RX_CODEB_EN (Code-B segment decode output).
// ---------------------------------------------------------------------------
module spi_display_receiver
    import spi_display_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    res,
    spi_display_if.slave            spi,
    output logic                    word_valid,
    output logic [FRAME_BITS-1:0]   word_out,
    output logic                    frame_err,
    output logic [NUM_DIGITS*8-1:0] digits,
    output logic [7:0]              decode_mode,
    output logic [3:0]              intensity,
    output logic [2:0]              scan_limit,
    output logic                    shutdown,
`ifdef SPI_RX_CODEB_EN
    output logic [NUM_DIGITS*8-1:0] segs,
`endif
    output logic                    display_test
);

    localparam logic [4:0] BIT_CNT_FULL = 5'(FRAME_BITS);
    localparam logic [4:0] BIT_CNT_SAT  = 5'(FRAME_BITS + 1);

    logic sck_level, sck_rise, sck_fall;
    logic cs_level,  cs_rise,  cs_fall;
    logic mosi_level, mosi_rise, mosi_fall;

    spi_rx_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk(clk), .res(res), .din(spi.sck),
        .level(sck_level), .rise(sck_rise), .fall(sck_fall)
    );

    spi_rx_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .res(res), .din(spi.cs),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );

    spi_rx_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .res(res), .din(spi.mosi),
        .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
    );

    // Only the sck rise, cs edges and mosi level are used; the rest exist
    // because the synchronizer is shared.
    logic unused_sync;
    assign unused_sync = ^{sck_level, sck_fall, cs_level, mosi_rise, mosi_fall};

    rx_state_e                   state_q, state_d;
    logic [FRAME_BITS-1:0]       shreg_q, shreg_d;
    logic [4:0]                  bit_cnt_q, bit_cnt_d;
    logic                        word_valid_q, word_valid_d;
    logic                        frame_err_q, frame_err_d;
    logic [FRAME_BITS-1:0]       word_q, word_d;
    logic [NUM_DIGITS-1:0][7:0]  digits_q, digits_d;
    logic [7:0]                  decode_q, decode_d;
    logic [3:0]                  intensity_q, intensity_d;
    logic [2:0]                  scan_q, scan_d;
    logic                        shutdown_q, shutdown_d;
    logic                        test_q, test_d;

    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    assign wr_addr = shreg_q[11:8];
    assign wr_data = shreg_q[7:0];

    // NOTE: every variable gets a default at the top of the block, so paths
    // that do not assign it hold state instead of inferring a latch.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        word_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        word_d       = word_q;
        digits_d     = digits_q;
        decode_d     = decode_q;
        intensity_d  = intensity_q;
        scan_d       = scan_q;
        shutdown_d   = shutdown_q;
        test_d       = test_q;

        if (cs_fall) begin
            // A new select always restarts the frame.
            state_d   = ST_SHIFT;
            shreg_d   = '0;
            bit_cnt_d = '0;
        end else if (state_q == ST_SHIFT) begin
            if (cs_rise) begin
                // Commit cycle; an sck edge coinciding with it is dropped.
                state_d = ST_IDLE;
                if (bit_cnt_q == BIT_CNT_FULL) begin
                    word_valid_d = 1'b1;
                    word_d       = shreg_q;
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (wr_addr == ADDR_DIGIT0 + 4'(i)) digits_d[i] = wr_data;
                    end
                    case (wr_addr)
                        ADDR_DECODE:    decode_d    = wr_data;
                        ADDR_INTENSITY: intensity_d = wr_data[3:0];
                        ADDR_SCANLIMIT: scan_d      = wr_data[2:0];
                        ADDR_SHUTDOWN:  shutdown_d  = ~wr_data[0];
                        ADDR_TEST:      test_d      = wr_data[0];
                        default:        ;
                    endcase
                end else begin
                    frame_err_d = 1'b1;
                end
            end else if (sck_rise) begin
                shreg_d = {shreg_q[FRAME_BITS-2:0], mosi_level};
                if (bit_cnt_q != BIT_CNT_SAT) bit_cnt_d = bit_cnt_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            word_q       <= '0;
            digits_q     <= '0;
            decode_q     <= '0;
            intensity_q  <= '0;
            scan_q       <= '0;
            shutdown_q   <= 1'b1;
            test_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            word_valid_q <= word_valid_d;
            frame_err_q  <= frame_err_d;
            word_q       <= word_d;
            digits_q     <= digits_d;
            decode_q     <= decode_d;
            intensity_q  <= intensity_d;
            scan_q       <= scan_d;
            shutdown_q   <= shutdown_d;
            test_q       <= test_d;
        end
    end

    assign word_valid   = word_valid_q;
    assign word_out     = word_q;
    assign frame_err    = frame_err_q;
    assign digits       = digits_q;
    assign decode_mode  = decode_q;
    assign intensity    = intensity_q;
    assign scan_limit   = scan_q;
    assign shutdown     = shutdown_q;
    assign display_test = test_q;

`ifdef SPI_RX_CODEB_EN
    always_comb begin
        segs = '0;
        if (!shutdown_q) begin
            if (test_q) begin
                segs = '1;
            end else begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (decode_q[i]) begin
                        segs[8*i +: 8] = {digits_q[i][7], code_b_font(digits_q[i][3:0])};
                    end else begin
                        segs[8*i +: 8] = digits_q[i];
                    end
                end
            end
        end
    end
`endif

endmodule
